// File: rtl/mprj_io_cfg_bank.sv
`default_nettype none
// ============================================================================
// Module   : mprj_io_cfg_bank
// Brief    : Wishbone bank of per-pad IO config words plus power-control word,
//            serialised onto the pad configuration shift chain on request.
//            Optional transfer-done interrupt: define MPRJ_CFG_IRQ_EN.
// Revision : 1.0  initial release
// ============================================================================
module mprj_io_cfg_bank #(
    parameter logic [31:0]      BASE_ADR = 32'h2600_0000,
    parameter int               NUM_IO   = 38,
    parameter int               CFG_W    = 13,
    parameter int               PWR_W    = 4,
    parameter logic [CFG_W-1:0] CFG_INIT = 13'h0403,
    parameter int               CLK_DIV  = 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rstn_i,
    input  logic             wb_stb_i,
    input  logic             wb_cyc_i,
    input  logic             wb_we_i,
    input  logic [3:0]       wb_sel_i,
    input  logic [31:0]      wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    output logic             wb_ack_o,
    output logic [31:0]      wb_dat_o,
    output logic             serial_clock_o,
    output logic             serial_data_o,
    output logic             serial_load_o,
    output logic [PWR_W-1:0] pwr_ctrl_o,
    output logic             xfer_busy_o,
    output logic             irq_o
);

    localparam int c_IO_W  = (NUM_IO > 1)  ? $clog2(NUM_IO)  : 1;
    localparam int c_BIT_W = (CFG_W > 1)   ? $clog2(CFG_W)   : 1;
    localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_IO_W-1:0]  c_IO_LAST  = c_IO_W'(NUM_IO - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(CFG_W - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [6:0]         c_NUM_IO   = 7'(NUM_IO);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SHIFT_LO = 2'd1,
        S_SHIFT_HI = 2'd2,
        S_LOAD     = 2'd3
    } state_t;

    logic [CFG_W-1:0]   r_io_cfg [NUM_IO];
    logic [PWR_W-1:0]   r_pwr;
    logic               r_ack, r_start, r_done, r_drop, r_busy;
    logic [31:0]        r_dat;
    state_t             r_state;
    logic [c_IO_W-1:0]  r_io_idx;
    logic [c_BIT_W-1:0] r_bit_idx;
    logic [c_DIV_W-1:0] r_div;
    logic               r_sclk, r_sdat, r_sload;

    logic               w_hit, w_req, w_wr, w_is_xfer, w_is_pwr, w_is_io;
    logic               w_busy_any, w_xfer_wr, w_done_set, w_drop_set, w_ie;
    logic               w_div_end, w_unused;
    logic [9:0]         w_word;
    logic [c_IO_W-1:0]  w_io_idx, w_next_io;
    logic [c_BIT_W-1:0] w_next_bit;
    logic [31:0]        w_rdata;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++)
            if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
        return res;
    endfunction

    assign w_hit      = (wb_adr_i[31:12] == BASE_ADR[31:12]);
    assign w_req      = wb_stb_i & wb_cyc_i & ~r_ack & w_hit;
    assign w_wr       = w_req & wb_we_i;
    assign w_word     = wb_adr_i[11:2];
    assign w_unused   = &{1'b0, wb_adr_i[1:0]};
    assign w_is_xfer  = (w_word == 10'd0);
    assign w_is_pwr   = (w_word == 10'd1);
    assign w_is_io    = (w_word[9:6] == 4'd1) && ({1'b0, w_word[5:0]} < c_NUM_IO);
    assign w_io_idx   = w_word[c_IO_W-1:0];
    // A start still in flight counts as busy so IO writes cannot race the first shift.
    assign w_busy_any = r_busy | r_start;
    assign w_xfer_wr  = w_wr & w_is_xfer & wb_sel_i[0];
    assign w_div_end  = (r_div == c_DIV_LAST);
    assign w_done_set = (r_state == S_LOAD) && w_div_end;
    assign w_drop_set = w_wr & w_is_io & w_busy_any;
    assign w_next_bit = (r_bit_idx == '0) ? c_BIT_LAST : r_bit_idx - 1'b1;
    assign w_next_io  = (r_bit_idx == '0) ? r_io_idx - 1'b1 : r_io_idx;

    always_comb begin
        w_rdata = '0;
        if (w_is_xfer)     w_rdata = {28'b0, w_ie, r_drop, r_done, r_busy};
        else if (w_is_pwr) w_rdata = 32'(r_pwr);
        else if (w_is_io)  w_rdata = 32'(r_io_cfg[w_io_idx]);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            r_ack   <= 1'b0;
            r_dat   <= '0;
            r_pwr   <= '0;
            r_start <= 1'b0;
            for (int i = 0; i < NUM_IO; i++) r_io_cfg[i] <= CFG_INIT;
        end else begin
            r_ack   <= w_req;
            r_dat   <= (w_req && !wb_we_i) ? w_rdata : '0;
            r_start <= w_xfer_wr & wb_dat_i[0] & ~w_busy_any;
            if (w_wr && w_is_pwr)
                r_pwr <= PWR_W'(f_merge(32'(r_pwr), wb_dat_i, wb_sel_i));
            if (w_wr && w_is_io && !w_busy_any)
                r_io_cfg[w_io_idx] <= CFG_W'(f_merge(32'(r_io_cfg[w_io_idx]), wb_dat_i, wb_sel_i));
        end
    end

    // Hardware set takes priority over a software clear in the same cycle.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            r_done <= 1'b0;
            r_drop <= 1'b0;
        end else begin
            r_done <= w_done_set | (r_done & ~(w_xfer_wr & wb_dat_i[1]));
            r_drop <= w_drop_set | (r_drop & ~(w_xfer_wr & wb_dat_i[2]));
        end
    end

`ifdef MPRJ_CFG_IRQ_EN
    logic r_ie;
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i)     r_ie <= 1'b0;
        else if (w_xfer_wr) r_ie <= wb_dat_i[3];
    end
    assign w_ie  = r_ie;
    assign irq_o = r_done & r_ie;
`else
    assign w_ie  = 1'b0;
    assign irq_o = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            r_state   <= S_IDLE;
            r_io_idx  <= '0;
            r_bit_idx <= '0;
            r_div     <= '0;
            r_sclk    <= 1'b0;
            r_sdat    <= 1'b0;
            r_sload   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_start) begin
                        r_state   <= S_SHIFT_LO;
                        r_io_idx  <= c_IO_LAST;
                        r_bit_idx <= c_BIT_LAST;
                        r_div     <= '0;
                        r_sdat    <= r_io_cfg[c_IO_LAST][c_BIT_LAST];
                        r_busy    <= 1'b1;
                    end
                end
                S_SHIFT_LO: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_sclk  <= 1'b1;
                        r_state <= S_SHIFT_HI;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_SHIFT_HI: begin
                    if (w_div_end) begin
                        r_div  <= '0;
                        r_sclk <= 1'b0;
                        if (r_io_idx == '0 && r_bit_idx == '0) begin
                            r_state <= S_LOAD;
                            r_sdat  <= 1'b0;
                            r_sload <= 1'b1;
                        end else begin
                            r_io_idx  <= w_next_io;
                            r_bit_idx <= w_next_bit;
                            r_sdat    <= r_io_cfg[w_next_io][w_next_bit];
                            r_state   <= S_SHIFT_LO;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_LOAD: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_sload <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wb_ack_o       = r_ack;
    assign wb_dat_o       = r_dat;
    assign serial_clock_o = r_sclk;
    assign serial_data_o  = r_sdat;
    assign serial_load_o  = r_sload;
    assign pwr_ctrl_o     = r_pwr;
    assign xfer_busy_o    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mprj_io_cfg_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_mprj_io_cfg_bank
// Brief    : Directed scoreboard bench: a default-size bank (A) for the register
//            map and a 2x4-bit, CLK_DIV=1 bank (B) for the serial chain.
// Revision : 1.0  initial release
// ============================================================================
module tb_mprj_io_cfg_bank;

    localparam logic [31:0] c_BASE = 32'h2600_0000;
    localparam logic [31:0] c_XFER = c_BASE;
    localparam logic [31:0] c_PWR  = c_BASE + 32'h4;
    localparam logic [31:0] c_IO0  = c_BASE + 32'h100;
    localparam int          c_NIO  = 38;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb_a, stb_b, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack_a, ack_b, sclk_a, sclk_b, sdat_a, sdat_b, sload_a, sload_b;
    logic        busy_a, busy_b, irq_a, irq_b;
    logic [31:0] dat_a, dat_b;
    logic [3:0]  pwr_a, pwr_b;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];
    string       tag_q [$];
    logic [12:0] cfg_exp [c_NIO];

    always #5 clk = ~clk;

    mprj_io_cfg_bank dut_a (
        .wb_clk_i(clk), .wb_rstn_i(rst_n), .wb_stb_i(stb_a), .wb_cyc_i(cyc),
        .wb_we_i(we), .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(wdat),
        .wb_ack_o(ack_a), .wb_dat_o(dat_a), .serial_clock_o(sclk_a),
        .serial_data_o(sdat_a), .serial_load_o(sload_a), .pwr_ctrl_o(pwr_a),
        .xfer_busy_o(busy_a), .irq_o(irq_a)
    );

    mprj_io_cfg_bank #(
        .NUM_IO(2), .CFG_W(4), .PWR_W(4), .CFG_INIT(4'h3), .CLK_DIV(1)
    ) dut_b (
        .wb_clk_i(clk), .wb_rstn_i(rst_n), .wb_stb_i(stb_b), .wb_cyc_i(cyc),
        .wb_we_i(we), .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(wdat),
        .wb_ack_o(ack_b), .wb_dat_o(dat_b), .serial_clock_o(sclk_b),
        .serial_data_o(sdat_b), .serial_load_o(sload_b), .pwr_ctrl_o(pwr_b),
        .xfer_busy_o(busy_b), .irq_o(irq_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // lat = cycles from request to ack (1 is the only legal value), 0 = never acked.
    task automatic bus(input bit b, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd, output int lat);
        @(negedge clk);
        adr = a; wdat = d; sel = s; we = w; cyc = 1'b1;
        if (b) stb_b = 1'b1; else stb_a = 1'b1;
        rd  = 'x;
        lat = 0;
        for (int i = 1; i <= 4 && lat == 0; i++) begin
            @(negedge clk);
            if ((b ? ack_b : ack_a) === 1'b1) begin
                lat = i;
                rd  = b ? dat_b : dat_a;
            end
        end
        stb_a = 1'b0; stb_b = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic rd_chk(input bit b, input logic [31:0] a, input logic [31:0] e, input string tag);
        logic [31:0] rd, exp_v;
        int          lat;
        string       t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        bus(b, 1'b0, a, 32'h0, 4'hF, rd, lat);
        exp_v = exp_q.pop_front();
        t     = tag_q.pop_front();
        chk(t, (lat == 1) ? rd : 32'hxxxx_xxxx, exp_v);
    endtask

    task automatic wr(input bit b, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input string tag);
        logic [31:0] rd;
        int          lat;
        bus(b, 1'b1, a, d, s, rd, lat);
        chk({tag, "_ack"}, 32'(lat), 32'd1);
    endtask

    task automatic run_xfer(output int busy_n, output int load_n, output logic [7:0] bits,
                            output bit first_busy, output bit finished, output bit irq_seen);
        bit prev_clk = 1'b0;
        bit seen = 1'b0;
        busy_n = 0; load_n = 0; bits = '0; finished = 1'b0; irq_seen = 1'b0;
        for (int i = 0; i < 200 && !finished; i++) begin
            @(negedge clk);
            if (i == 0) first_busy = busy_b;
            if (busy_b) begin busy_n++; seen = 1'b1; end
            if (sload_b) load_n++;
            if (sclk_b && !prev_clk) bits = {bits[6:0], sdat_b};
            prev_clk = sclk_b;
            if (!busy_b) irq_seen = irq_seen | irq_b;
            if (seen && !busy_b) finished = 1'b1;
        end
    endtask

    initial begin
        int          busy_n, load_n, lat;
        logic [7:0]  bits;
        logic [31:0] v, rd;
        bit          first_busy, finished, irq_seen;

        rst_n = 1'b0; stb_a = 1'b0; stb_b = 1'b0; cyc = 1'b0; we = 1'b0;
        sel = 4'h0; adr = '0; wdat = '0;
        repeat (3) @(negedge clk);
        chk("rst_outs_a", {24'b0, ack_a, sclk_a, sdat_a, sload_a, busy_a, irq_a, pwr_a[1:0]} | 32'(pwr_a), 32'h0);
        chk("rst_dat_a", dat_a, 32'h0);
        rst_n = 1'b1;

        // Bank A: reset values, ack width, register map.
        for (int i = 0; i < c_NIO; i++)
            rd_chk(1'b0, c_IO0 + 32'(4 * i), 32'h403, $sformatf("io_rst%0d", i));
        rd_chk(1'b0, c_PWR, 32'h0, "pwr_rst");
        rd_chk(1'b0, c_XFER, 32'h0, "xfer_rst");
        @(negedge clk);
        chk("ack_width", 32'(ack_a), 32'h0);

        for (int i = 0; i < c_NIO; i++) begin
            v          = $urandom;
            cfg_exp[i] = v[12:0];
            wr(1'b0, c_IO0 + 32'(4 * i), v, 4'hF, "io_wr");
        end
        for (int i = 0; i < c_NIO; i++)
            rd_chk(1'b0, c_IO0 + 32'(4 * i), 32'(cfg_exp[i]), $sformatf("io_rb%0d", i));

        wr(1'b0, c_IO0, 32'h403, 4'hF, "io0_init");
        wr(1'b0, c_IO0, 32'hFFFF_FFFF, 4'h1, "io0_sel1");
        rd_chk(1'b0, c_IO0, 32'h4FF, "io0_sel1_rb");
        wr(1'b0, c_IO0 + 32'h4, 32'h0000_1F00, 4'h2, "io1_sel2");
        rd_chk(1'b0, c_IO0 + 32'h4, 32'((cfg_exp[1] & 13'h00FF) | 13'h1F00), "io1_sel2_rb");

        wr(1'b0, c_PWR, 32'hFFFF_FFFF, 4'hF, "pwr_all");
        rd_chk(1'b0, c_PWR, 32'hF, "pwr_all_rb");
        chk("pwr_port", 32'(pwr_a), 32'hF);
        wr(1'b0, c_PWR, 32'h0, 4'h2, "pwr_sel2");
        rd_chk(1'b0, c_PWR, 32'hF, "pwr_sel2_rb");
        wr(1'b0, c_PWR, 32'h5, 4'h1, "pwr_sel1");
        rd_chk(1'b0, c_PWR, 32'h5, "pwr_sel1_rb");

        wr(1'b0, c_BASE + 32'h8, 32'hFFFF_FFFF, 4'hF, "unmapped_wr");
        rd_chk(1'b0, c_BASE + 32'h8, 32'h0, "unmapped_rd");
        rd_chk(1'b0, c_IO0 + 32'(4 * c_NIO), 32'h0, "io_past_end");
        bus(1'b0, 1'b0, c_BASE + 32'h1000, 32'h0, 4'hF, rd, lat);
        chk("nohit_ack", 32'(lat), 32'h0);

        // Bank B: serial chain.
        wr(1'b1, c_IO0 + 32'h4, 32'hA, 4'hF, "b_io1");
        wr(1'b1, c_IO0, 32'h5, 4'hF, "b_io0");
        exp_q.push_back(32'hA5);
        tag_q.push_back("serial_bits");
        wr(1'b1, c_XFER, 32'h1, 4'hF, "b_start");
        chk("busy_at_ack", 32'(busy_b), 32'h0);
        run_xfer(busy_n, load_n, bits, first_busy, finished, irq_seen);
        chk("busy_next", 32'(first_busy), 32'h1);
        chk("xfer_finished", 32'(finished), 32'h1);
        chk(tag_q.pop_front(), 32'(bits), exp_q.pop_front());
        chk("busy_cycles", 32'(busy_n), 32'd17);
        chk("load_cycles", 32'(load_n), 32'd1);
        rd_chk(1'b1, c_XFER, 32'h2, "done_set");

        wr(1'b1, c_XFER, 32'h1, 4'hF, "b_start2");
        wr(1'b1, c_IO0, 32'hF, 4'hF, "drop_wr");
        run_xfer(busy_n, load_n, bits, first_busy, finished, irq_seen);
        chk("xfer2_finished", 32'(finished), 32'h1);
        rd_chk(1'b1, c_IO0, 32'h5, "drop_io_kept");
        rd_chk(1'b1, c_XFER, 32'h6, "drop_set");
        wr(1'b1, c_XFER, 32'h4, 4'hF, "drop_clr");
        rd_chk(1'b1, c_XFER, 32'h2, "drop_clr_rb");
        wr(1'b1, c_XFER, 32'h2, 4'hF, "done_clr");
        rd_chk(1'b1, c_XFER, 32'h0, "done_clr_rb");

        // Reset in the middle of a transfer.
        wr(1'b1, c_PWR, 32'hF, 4'hF, "b_pwr");
        wr(1'b1, c_XFER, 32'h1, 4'hF, "b_start3");
        repeat (4) @(negedge clk);
        chk("busy_pre_rst", 32'(busy_b), 32'h1);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_outs", {24'b0, ack_b, sclk_b, sdat_b, sload_b, busy_b, irq_b, 2'b0} | 32'(pwr_b), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        load_n = 0; busy_n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (sload_b) load_n++;
            if (busy_b) busy_n++;
        end
        chk("no_load_after_rst", 32'(load_n), 32'h0);
        chk("no_busy_after_rst", 32'(busy_n), 32'h0);
        rd_chk(1'b1, c_IO0 + 32'h4, 32'h3, "io_rst_after_abort");

`ifdef MPRJ_CFG_IRQ_EN
        wr(1'b1, c_XFER, 32'h8, 4'hF, "ie_set");
        rd_chk(1'b1, c_XFER, 32'h8, "ie_rb");
        chk("irq_idle", 32'(irq_b), 32'h0);
        wr(1'b1, c_XFER, 32'h9, 4'hF, "b_start_irq");
        run_xfer(busy_n, load_n, bits, first_busy, finished, irq_seen);
        chk("irq_on_done", 32'(irq_b), 32'h1);
        wr(1'b1, c_XFER, 32'hA, 4'hF, "irq_clr");
        @(negedge clk);
        chk("irq_cleared", 32'(irq_b), 32'h0);
        rd_chk(1'b1, c_XFER, 32'h8, "irq_clr_rb");
`else
        wr(1'b1, c_XFER, 32'h8, 4'hF, "ie_set");
        rd_chk(1'b1, c_XFER, 32'h0, "ie_reads_zero");
        wr(1'b1, c_XFER, 32'h1, 4'hF, "b_start_irq");
        run_xfer(busy_n, load_n, bits, first_busy, finished, irq_seen);
        chk("irq_never", 32'(irq_seen | irq_b), 32'h0);
        rd_chk(1'b1, c_XFER, 32'h2, "done_no_irq");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
